// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX byte stream among NUM_REQ requesters.
// Define UART_ARB_HDR_EN to prefix each packet with a header byte 8'hA0 | grant_idx (DATA_W must be 8).
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_valid,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_ready,
  output logic                        grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
  output logic                        trunc_pulse
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic [CNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic               trunc_reg, trunc_next;

  logic [DATA_W-1:0]  req_bytes [NUM_REQ];
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   next_ptr;
  int                 cand;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign next_ptr = (grant_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_idx_next = grant_idx_reg;
    byte_cnt_next  = byte_cnt_reg;
    trunc_next     = 1'b0;
    tx_valid       = 1'b0;
    tx_data        = '0;
    req_ready      = '0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_idx_next = pick_idx;
          byte_cnt_next  = '0;
`ifdef UART_ARB_HDR_EN
          state_next     = HDR;
`else
          state_next     = XFER;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = DATA_W'(8'hA0 | 8'(grant_idx_reg));
        if (tx_ready) state_next = XFER;
      end
`endif
      XFER: begin
        tx_valid                 = req_valid[grant_idx_reg];
        req_ready[grant_idx_reg] = tx_ready;
        if (tx_valid) tx_data = req_bytes[grant_idx_reg];
        if (tx_valid && tx_ready) begin
          byte_cnt_next = byte_cnt_reg + 1'b1;
          // Release on the last byte, or force release once the length limit is hit.
          if (req_last[grant_idx_reg] || byte_cnt_reg == CNT_W'(MAX_PKT_LEN - 1)) begin
            state_next     = IDLE;
            rr_ptr_next    = next_ptr;
            grant_idx_next = '0;
            trunc_next     = !req_last[grant_idx_reg];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_idx_reg <= '0;
      byte_cnt_reg  <= '0;
      trunc_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_idx_reg <= grant_idx_next;
      byte_cnt_reg  <= byte_cnt_next;
      trunc_reg     <= trunc_next;
    end
  end

  assign grant_valid = (state_reg != IDLE);
  assign grant_idx   = grant_idx_reg;
  assign trunc_pulse = trunc_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, MAX_PKT_LEN=4, header feature off).
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          grant_valid;
  logic [1:0]    grant_idx;
  logic          trunc_pulse;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_PKT_LEN(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .trunc_pulse(trunc_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-requester byte source: fixed byte lists consumed on handshakes.
  logic [7:0] mem  [NR][16];
  logic       lmem [NR][16];
  int         len  [NR];
  int         pos  [NR];
  logic [NR-1:0] en;
  logic [7:0] t3 [6] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && pos[i] < len[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = mem[i][pos[i]];
        req_last[i]           = lmem[i][pos[i]];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [NR-1:0] hs;
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) pos[i]++;
    drive();
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic l);
    mem[i][len[i]]  = d;
    lmem[i][len[i]] = l;
    len[i]++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = '0;
    drive();
    tick();
    tick();
    for (int i = 0; i < NR; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    rst = 1'b0;
    drive();
  endtask

  initial begin
    rst = 1'b1; tx_ready = 1'b1; en = '0;
    req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < NR; i++) begin len[i] = 0; pos[i] = 0; end

    // Reset state
    do_reset();
    #1;
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_trunc", trunc_pulse, 0);

    // Round robin 0,1,2,3,0 with 2-byte packets and one bubble between packets
    do_reset();
    load(0, 8'h10, 0); load(0, 8'h11, 1); load(0, 8'h10, 0); load(0, 8'h11, 1);
    load(1, 8'h20, 0); load(1, 8'h21, 1);
    load(2, 8'h30, 0); load(2, 8'h31, 1);
    load(3, 8'h40, 0); load(3, 8'h41, 1);
    en = 4'hF; tx_ready = 1'b1; drive();
    for (int c = 0; c < 15; c++) begin
      int ph, g;
      ph = c % 3; g = (c / 3) % 4;
      #1;
      if (ph == 0) begin
        check("rr_bubble_gv", grant_valid, 0);
        check("rr_bubble_txv", tx_valid, 0);
      end else begin
        check("rr_gv", grant_valid, 1);
        check("rr_gidx", grant_idx, g);
        check("rr_txv", tx_valid, 1);
        check("rr_data", tx_data, (g + 1) * 16 + ph - 1);
        check("rr_ready", req_ready, 1 << g);
      end
      tick();
    end

    // Req 2 alone, tx_ready toggling
    do_reset();
    load(2, 8'h11, 0); load(2, 8'h22, 0); load(2, 8'h33, 1);
    en = 4'b0100; drive();
    for (int c = 0; c < 8; c++) begin
      tx_ready = (c % 2 == 0);
      #1;
      if (c >= 1 && c <= 6) begin
        check("bp_txv", tx_valid, 1);
        check("bp_data", tx_data, t3[c-1]);
        check("bp_ready", req_ready, tx_ready ? 4'b0100 : 4'b0000);
      end else begin
        check("bp_idle_gv", grant_valid, 0);
      end
      tick();
    end

    // Truncation at MAX_PKT_LEN=4
    do_reset();
    for (int k = 0; k < 6; k++) load(1, 8'hA1 + k[7:0], 0);
    en = 4'b0010; tx_ready = 1'b1; drive();
    for (int c = 0; c < 9; c++) begin
      #1;
      check("tr_pulse", trunc_pulse, c == 5);
      if (c >= 1 && c <= 4) check("tr_data", tx_data, 8'hA1 + c - 1);
      if (c == 5) check("tr_gv_low", grant_valid, 0);
      if (c == 6 || c == 7) begin
        check("tr_regrant", grant_idx, 1);
        check("tr_data2", tx_data, 8'hA5 + c - 6);
      end
      if (c == 8) begin
        check("tr_hold_gv", grant_valid, 1);
        check("tr_hold_txv", tx_valid, 0);
        check("tr_hold_data", tx_data, 0);
      end
      tick();
    end

    // Late request waits for the packet; next grant 3, then rr_ptr back at 0
    do_reset();
    load(0, 8'h01, 0); load(0, 8'h02, 0); load(0, 8'h03, 1);
    load(3, 8'h31, 1); load(3, 8'h32, 1);
    load(1, 8'h41, 1);
    en = 4'b0001; tx_ready = 1'b1; drive();
    for (int c = 0; c < 8; c++) begin
      if (c == 2) en[3] = 1'b1;
      if (c == 5) en[1] = 1'b1;
      drive();
      #1;
      if (c >= 1 && c <= 3) begin
        check("late_gidx", grant_idx, 0);
        check("late_data", tx_data, c);
        check("late_ready", req_ready, 4'b0001);
      end
      if (c == 4) check("late_gap", grant_valid, 0);
      if (c == 5) begin
        check("late_g3", grant_idx, 3);
        check("late_d3", tx_data, 8'h31);
      end
      if (c == 7) begin
        check("late_ptr", grant_idx, 1);
        check("late_d1", tx_data, 8'h41);
      end
      tick();
    end

    // Reset mid-packet
    do_reset();
    load(2, 8'h21, 1);
    for (int k = 0; k < 5; k++) load(3, 8'h31 + k[7:0], k == 4);
    load(1, 8'h41, 1);
    en = 4'b1100; tx_ready = 1'b1; drive();
    for (int c = 0; c < 8; c++) begin
      rst = (c == 5);
      if (c == 6) en[1] = 1'b1;
      drive();
      #1;
      if (c == 1) begin
        check("mr_g2", grant_idx, 2);
        check("mr_d2", tx_data, 8'h21);
      end
      if (c == 3) begin
        check("mr_g3", grant_idx, 3);
        check("mr_d3", tx_data, 8'h31);
      end
      if (c == 6) begin
        check("mr_txv", tx_valid, 0);
        check("mr_gv", grant_valid, 0);
        check("mr_gidx", grant_idx, 0);
      end
      if (c == 7) begin
        check("mr_regv", grant_valid, 1);
        check("mr_reg1", grant_idx, 1);
        check("mr_red", tx_data, 8'h41);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte stream between NUM_REQ requesters (e.g. debug console, telemetry, error reporter).
- Round-robin arbitration at packet granularity: a granted requester owns the UART until its last byte or a length-limit truncation.
- Sits between the requester byte streams and the UART TX valid/ready input.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 8, byte width; fixed at 8 when UART_ARB_HDR_EN is defined.
- MAX_PKT_LEN, 64, maximum payload handshakes per grant before forced release; legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  marks the final byte of a packet; qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester byte accept.
- tx_valid  out  1  byte valid toward the UART transmitter.
- tx_data  out  DATA_W  byte toward the UART transmitter.
- tx_ready  in  1  UART transmitter accepts the byte.
- grant_valid  out  1  a requester currently owns the UART.
- grant_idx  out  $clog2(NUM_REQ)  index of the owning requester; 0 when grant_valid=0.
- trunc_pulse  out  1  one-cycle pulse when a grant is force-released at MAX_PKT_LEN.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, rr_ptr=0, byte_cnt=0.
  - Outputs: grant_valid=0, grant_idx=0, trunc_pulse=0, tx_valid=0, tx_data=0, req_ready=0.
  - Reset mid-packet aborts the packet silently; no byte is emitted in the cycle after reset.
- Handshake: a byte transfers on a cycle where tx_valid && tx_ready. tx_valid never depends combinationally on tx_ready.
- IDLE:
  - tx_valid=0, req_ready=0.
  - If any req_valid bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register the selection into grant_idx, set grant_valid=1, clear byte_cnt.
  - Go to HDR if UART_ARB_HDR_EN is defined, else XFER.
  - Arbitration latency: 1 cycle from req_valid to grant_valid.
- XFER (combinational pass-through for the granted requester g):
  - tx_valid = req_valid[g]; tx_data = req_data[g]; req_ready[g] = tx_ready.
  - All other req_ready bits = 0. tx_data = 0 when tx_valid=0.
  - Each handshake increments byte_cnt.
  - Handshake with req_last[g]=1: go to IDLE, rr_ptr = (g+1) mod NUM_REQ, grant_valid=0.
  - Handshake bringing byte_cnt to MAX_PKT_LEN with req_last[g]=0: same release as above, plus trunc_pulse=1 for one cycle.
  - Subsequent bytes from g are treated as a new packet.
  - req_valid[g] deasserting mid-packet holds the grant (no timeout); tx_valid follows it low.
- Back-to-back packets always incur exactly one IDLE bubble cycle between the last byte of one packet and the first byte of the next.
- Fairness: requester i waits at most NUM_REQ-1 packets after raising req_valid.
- Requests arriving during XFER are ignored until IDLE.
- A requester that is the only one valid is re-granted immediately after its own release.
- NUM_REQ=2 wrap: rr_ptr toggles between 0 and 1.

Optional Feature:
- Macro: UART_ARB_HDR_EN.
- Defined:
  - Extra state HDR after IDLE: tx_valid=1, tx_data = 8'hA0 | grant_idx, all req_ready=0.
  - On handshake, go to XFER.
  - The header byte does not count toward byte_cnt.
  - Per-packet latency increases by one UART byte.
- Not defined:
  - No HDR state; IDLE goes directly to XFER.
  - Payload bytes only.

Test Plan:
- After reset, req_valid=4'b1111, each requester sends a 2-byte packet, tx_ready=1 -> grant order 0,1,2,3,0; exactly one bubble cycle between packets; tx_data matches each source in order.
- Only req 2 valid, 3-byte packet 0x11,0x22,0x33 with last on 0x33; tx_ready toggles 1,0,1,0,... -> bytes emitted in order, each exactly once; req_ready[2] mirrors tx_ready; no other req_ready bit set.
- MAX_PKT_LEN=4, req 1 streams 6 bytes with no last -> trunc_pulse high one cycle after the 4th handshake; grant_valid=0 for one cycle; remaining 2 bytes are sent under a new grant to req 1.
- Req 0 granted, then req 3 raises valid mid-packet -> req 3 is not served until req 0's last byte; next grant_idx=3; rr_ptr then=0.
- rst=1 asserted after 2 of 5 bytes -> the next cycle shows tx_valid=0, grant_valid=0, rr_ptr=0; with req_valid=4'b1010 re-asserted, grant goes to req 1.
- UART_ARB_HDR_EN defined, req 3 sends 0x55 with last -> tx bytes are 0xA3 then 0x55; byte_cnt counts 1.
